exception_trap_controller: RTL

- Sits directly downstream of the exception handle unit in the 16-bit datapath and consumes its exception_flag.
- On an exception it:
  - captures the faulting PC and cause,
  - stalls and flushes the pipeline,
  - redirects the PC to a fixed handler vector,
  - returns to EPC+1 when the handler completes.
- A second exception while the handler is running is unrecoverable: the block halts until reset.

---
 rtl/exception_trap_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/exception_trap_controller.sv
// Exception trap controller: captures faulting PC/cause, flushes the pipeline,
// vectors to the handler and returns to EPC+1; a nested exception halts until reset.
module exception_trap_controller #(
    parameter logic [15:0] VECTOR_ADDR  = 16'h00F0,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          COUNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_flag,
    input  logic [15:0]        exc_instr,
    input  logic [15:0]        exc_pc,
    input  logic               exc_ovf,
    input  logic               ret_req,
    output logic               stall,
    output logic               flush,
    output logic               pc_load,
    output logic [15:0]        pc_target,
    output logic [15:0]        epc,
    output logic [1:0]         ecause,
    output logic [COUNT_W-1:0] exc_count,
    output logic               in_handler,
    output logic               halted,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        FLUSH   = 3'd2,
        VECTOR  = 3'd3,
        HANDLER = 3'd4,
        RETURN  = 3'd5,
        HALT    = 3'd6
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t               state_q, state_d;
    logic [3:0]           fcnt_q, fcnt_d;
    logic [15:0]          epc_q;
    logic [1:0]           ecause_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 stall_q, flush_q, pc_load_q, in_handler_q, halted_q;
    logic [15:0]          pc_target_q;

    logic [3:0]           opcode;
    logic                 ill;
    logic [1:0]           ecause_next;
    logic                 take_exc;
    logic                 unused_instr_bits;

    assign opcode            = exc_instr[15:12];
    assign unused_instr_bits = ^exc_instr[11:0];

    always_comb begin
        ill = 1'b1;
        case (opcode)
            4'h0, 4'h4, 4'h5, 4'h6, 4'h8, 4'hB, 4'hC, 4'hF: ill = 1'b0;
            default:                                        ill = 1'b1;
        endcase
        ecause_next = {exc_ovf, ill};
        if (ecause_next == 2'b00) ecause_next = 2'b11;
    end

    // Only IDLE and HANDLER accept exceptions; anything else is being squashed.
    assign take_exc = exc_flag && (state_q == IDLE || state_q == HANDLER);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE:    if (exc_flag) state_d = CAPTURE;
            CAPTURE: begin
                state_d = FLUSH;
                fcnt_d  = FLUSH_LAST;
            end
            FLUSH:   if (fcnt_q == 4'd0) state_d = VECTOR;
                     else                fcnt_d  = fcnt_q - 4'd1;
            VECTOR:  state_d = HANDLER;
            HANDLER: if (exc_flag)     state_d = HALT;
                     else if (ret_req) state_d = RETURN;
            RETURN:  state_d = IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered as a decode of the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fcnt_q       <= 4'd0;
            epc_q        <= 16'h0000;
            ecause_q     <= 2'b00;
            count_q      <= '0;
            stall_q      <= 1'b0;
            flush_q      <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_target_q  <= 16'h0000;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (state_q == IDLE && exc_flag) begin
                epc_q    <= exc_pc;
                ecause_q <= ecause_next;
            end
            if (take_exc && count_q != {COUNT_W{1'b1}})
                count_q <= count_q + 1'b1;
            stall_q      <= state_d inside {CAPTURE, FLUSH, VECTOR, RETURN, HALT};
            flush_q      <= state_d inside {CAPTURE, FLUSH};
            pc_load_q    <= state_d inside {VECTOR, RETURN};
            in_handler_q <= (state_d == HANDLER);
            halted_q     <= (state_d == HALT);
            if (state_d == VECTOR)      pc_target_q <= VECTOR_ADDR;
            else if (state_d == RETURN) pc_target_q <= epc_q + 16'd1;
            else                        pc_target_q <= 16'h0000;
        end
    end

    assign stall      = stall_q;
    assign flush      = flush_q;
    assign pc_load    = pc_load_q;
    assign pc_target  = pc_target_q;
    assign epc        = epc_q;
    assign ecause     = ecause_q;
    assign exc_count  = count_q;
    assign in_handler = in_handler_q;
    assign halted     = halted_q;
    assign state_dbg  = state_q;

endmodule
